// File: rtl/sprite_motion_pkg.sv
// Purpose: shared types and constants for the sprite motion integrator.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents:
//   state_t       frame-update FSM encoding (IDLE, STEP_X, STEP_Y, DONE)
//   DIR_POS/NEG   effective direction encoding (1 = towards the larger coordinate)
//   DEF_*         default screen geometry for a 640x480 display and a 16x16 sprite
package sprite_motion_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP_X = 2'd1,
        STEP_Y = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic DIR_POS = 1'b1;
    localparam logic DIR_NEG = 1'b0;

    localparam int DEF_POS_W    = 10;
    localparam int DEF_X_MAX    = 624;
    localparam int DEF_Y_MAX    = 464;
    localparam int DEF_X_INIT   = 312;
    localparam int DEF_Y_INIT   = 232;
    localparam int DEF_MAX_STEP = 15;

endpackage

// File: rtl/sprite_motion_axis_step.sv
// Purpose: single-axis step: saturate speed, apply direction, clamp (or reflect) at 0 / maxPos.
// Latency: purely combinational; the owner registers nextPos and hit.
// Backpressure: none, it is a function of its inputs.
//
// Ports:
//   pos      current coordinate on this axis
//   speed    full 32-bit unsigned pixels/frame; compared in full before saturation
//   dir      raw direction bit (1 = towards maxPos)
//   flip     per-axis reversal bit owned by the caller
//   maxPos   largest legal coordinate on this axis
//   nextPos  coordinate after this frame's step
//   hit      the step reached a bound (never set when the step is zero)
// Build option: SPRITE_MOTION_BOUNCE_EN selects reflection of the overshoot instead of clamping.
module axis_step
    import sprite_motion_pkg::*;
#(
    parameter int POS_W    = DEF_POS_W,
    parameter int MAX_STEP = DEF_MAX_STEP
) (
    input  logic [POS_W-1:0] pos,
    input  logic [31:0]      speed,
    input  logic             dir,
    input  logic             flip,
    input  logic [POS_W-1:0] maxPos,
    output logic [POS_W-1:0] nextPos,
    output logic             hit
);

    // One extra bit so pos+step cannot wrap before it is compared to the bound.
    localparam int EW = POS_W + 1;

    logic [POS_W-1:0] step;
    logic             dirEff;
    logic [EW-1:0]    posE;
    logic [EW-1:0]    stepE;
    logic [EW-1:0]    maxE;
    logic [EW-1:0]    sum;
`ifdef SPRITE_MOTION_BOUNCE_EN
    logic [EW-1:0]    over;
`endif

    always_comb begin
        // Speed is judged on all 32 bits; once it is known to be small the low bits are exact.
        step    = (speed > 32'(MAX_STEP)) ? POS_W'(MAX_STEP) : speed[POS_W-1:0];
        dirEff  = dir ^ flip;
        posE    = EW'(pos);
        stepE   = EW'(step);
        maxE    = EW'(maxPos);
        sum     = posE + stepE;
        nextPos = pos;
        hit     = 1'b0;
`ifdef SPRITE_MOTION_BOUNCE_EN
        over    = '0;
`endif

        if (step == '0) begin
            // Standing still never reports a hit, even when parked on a bound.
            nextPos = pos;
            hit     = 1'b0;
        end else if (dirEff == DIR_POS) begin
            if (sum >= maxE) begin
                hit = 1'b1;
`ifdef SPRITE_MOTION_BOUNCE_EN
                // Fold the overshoot back from the upper bound, never below zero.
                over    = sum - maxE;
                nextPos = (over > maxE) ? '0 : POS_W'(maxE - over);
`else
                nextPos = maxPos;
`endif
            end else begin
                nextPos = POS_W'(sum);
            end
        end else begin
            if (stepE >= posE) begin
                hit = 1'b1;
`ifdef SPRITE_MOTION_BOUNCE_EN
                // Fold the undershoot back from zero, never beyond the upper bound.
                over    = stepE - posE;
                nextPos = (over > maxE) ? maxPos : POS_W'(over);
`else
                nextPos = '0;
`endif
            end else begin
                nextPos = POS_W'(posE - stepE);
            end
        end
    end

endmodule

// File: rtl/sprite_motion.sv
// Purpose: integrate register-file speed/direction words into a clamped sprite position once per frame.
// Latency: tick sampled at edge 0, pos_x at edge 1, pos_y at edge 2, pos_valid high the following cycle.
// Backpressure: none; a frame_tick arriving while busy is dropped and flagged in sticky overrun.
//
// Ports:
//   clock, ctrl_reset_n          clock (rising edge) and asynchronous active-low reset
//   frame_tick, motion_en        per-frame pulse; ignored while motion_en is low
//   xSpeed/xDirection            x speed (unsigned) and direction (bit 0, 1 = right)
//   ySpeed/yDirection            y speed (unsigned) and direction (bit 0, 1 = down)
//   load_pos, load_x, load_y     synchronous position load, clamped, aborts any update
//   clear_status                 clears overrun (a simultaneous set wins)
//   pos_x, pos_y                 current sprite position
//   pos_valid                    one-cycle strobe once a frame update completes
//   hit_x, hit_y                 bound reached this frame, meaningful while pos_valid=1
//   busy, overrun                update in progress / tick dropped while busy (sticky)
// Build option: SPRITE_MOTION_BOUNCE_EN enables reflection at the bounds with per-axis flip bits.
module sprite_motion
    import sprite_motion_pkg::*;
#(
    parameter int POS_W    = DEF_POS_W,
    parameter int X_MAX    = DEF_X_MAX,
    parameter int Y_MAX    = DEF_Y_MAX,
    parameter int X_INIT   = DEF_X_INIT,
    parameter int Y_INIT   = DEF_Y_INIT,
    parameter int MAX_STEP = DEF_MAX_STEP
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic             frame_tick,
    input  logic             motion_en,
    input  logic [31:0]      xSpeed,
    input  logic [31:0]      xDirection,
    input  logic [31:0]      ySpeed,
    input  logic [31:0]      yDirection,
    input  logic             load_pos,
    input  logic [POS_W-1:0] load_x,
    input  logic [POS_W-1:0] load_y,
    input  logic             clear_status,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic             pos_valid,
    output logic             hit_x,
    output logic             hit_y,
    output logic             busy,
    output logic             overrun
);

    localparam logic [POS_W-1:0] X_MAX_P  = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] Y_MAX_P  = POS_W'(Y_MAX);
    localparam logic [POS_W-1:0] X_INIT_P = POS_W'(X_INIT);
    localparam logic [POS_W-1:0] Y_INIT_P = POS_W'(Y_INIT);

    state_t           state;
    logic             flipX;
    logic             flipY;
    logic [POS_W-1:0] xNext;
    logic [POS_W-1:0] yNext;
    logic             xHit;
    logic             yHit;
    logic [POS_W-1:0] loadXClamped;
    logic [POS_W-1:0] loadYClamped;

    // Only bit 0 of the direction words carries meaning.
    logic             unusedDirBits;
    assign unusedDirBits = ^{xDirection[31:1], yDirection[31:1]};

    assign loadXClamped = (load_x > X_MAX_P) ? X_MAX_P : load_x;
    assign loadYClamped = (load_y > Y_MAX_P) ? Y_MAX_P : load_y;

    // Both axes see live speed/direction; each result is only captured in its own STEP state.
    axis_step #(
        .POS_W    (POS_W),
        .MAX_STEP (MAX_STEP)
    ) uStepX (
        .pos     (pos_x),
        .speed   (xSpeed),
        .dir     (xDirection[0]),
        .flip    (flipX),
        .maxPos  (X_MAX_P),
        .nextPos (xNext),
        .hit     (xHit)
    );

    axis_step #(
        .POS_W    (POS_W),
        .MAX_STEP (MAX_STEP)
    ) uStepY (
        .pos     (pos_y),
        .speed   (ySpeed),
        .dir     (yDirection[0]),
        .flip    (flipY),
        .maxPos  (Y_MAX_P),
        .nextPos (yNext),
        .hit     (yHit)
    );

`ifndef SPRITE_MOTION_BOUNCE_EN
    assign flipX = 1'b0;
    assign flipY = 1'b0;
`endif

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state     <= IDLE;
            pos_x     <= X_INIT_P;
            pos_y     <= Y_INIT_P;
            pos_valid <= 1'b0;
            hit_x     <= 1'b0;
            hit_y     <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
`ifdef SPRITE_MOTION_BOUNCE_EN
            flipX     <= 1'b0;
            flipY     <= 1'b0;
`endif
        end else begin
            pos_valid <= 1'b0;

            // Status is independent of the FSM path taken; a set beats a clear in the same cycle.
            if (frame_tick && busy) begin
                overrun <= 1'b1;
            end else if (clear_status) begin
                overrun <= 1'b0;
            end

            if (load_pos) begin
                // A load discards any half-done frame, so no pos_valid follows it.
                pos_x <= loadXClamped;
                pos_y <= loadYClamped;
                state <= IDLE;
                busy  <= 1'b0;
`ifdef SPRITE_MOTION_BOUNCE_EN
                flipX <= 1'b0;
                flipY <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (frame_tick && motion_en) begin
                            state <= STEP_X;
                            busy  <= 1'b1;
                            hit_x <= 1'b0;
                            hit_y <= 1'b0;
                        end
                    end
                    STEP_X: begin
                        pos_x <= xNext;
                        hit_x <= xHit;
`ifdef SPRITE_MOTION_BOUNCE_EN
                        if (xHit) begin
                            flipX <= ~flipX;
                        end
`endif
                        state <= STEP_Y;
                    end
                    STEP_Y: begin
                        pos_y     <= yNext;
                        hit_y     <= yHit;
`ifdef SPRITE_MOTION_BOUNCE_EN
                        if (yHit) begin
                            flipY <= ~flipY;
                        end
`endif
                        state     <= DONE;
                        pos_valid <= 1'b1;
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_motion.sv
module tb_sprite_motion;

    localparam int XM = 624;
    localparam int YM = 464;

    logic        clock = 1'b0;
    logic        ctrl_reset_n;
    logic        frame_tick;
    logic        motion_en;
    logic [31:0] xSpeed, xDirection, ySpeed, yDirection;
    logic        load_pos;
    logic [9:0]  load_x, load_y;
    logic        clear_status;
    logic [9:0]  pos_x, pos_y;
    logic        pos_valid, hit_x, hit_y, busy, overrun;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: position, flip bits, last-frame hits.
    int mX, mY;
    bit mFX, mFY, mHX, mHY;

    // Observations captured by do_frame.
    logic [9:0] obsX1, obsY1, obsX2, obsY2;
    logic       obsV1, obsV2, obsV3, obsHX, obsHY, obsBusy0, obsBusy3;

    always #5 clock = ~clock;

    sprite_motion dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .frame_tick   (frame_tick),
        .motion_en    (motion_en),
        .xSpeed       (xSpeed),
        .xDirection   (xDirection),
        .ySpeed       (ySpeed),
        .yDirection   (yDirection),
        .load_pos     (load_pos),
        .load_x       (load_x),
        .load_y       (load_y),
        .clear_status (clear_status),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .pos_valid    (pos_valid),
        .hit_x        (hit_x),
        .hit_y        (hit_y),
        .busy         (busy),
        .overrun      (overrun)
    );

    // Behavioural reference of one axis, straight from the movement rules.
    function automatic void model_axis(input int pos, input logic [31:0] spd, input bit d,
                                       input bit flip, input int maxv, output int np, output bit h);
        int step;
        int o;
        step = (spd > 32'd15) ? 15 : int'(spd);
        np = pos;
        h  = 0;
        if (step == 0) return;
        if ((d ^ flip) == 1'b1) begin
            if (pos + step >= maxv) begin
                h = 1;
`ifdef SPRITE_MOTION_BOUNCE_EN
                o  = pos + step - maxv;
                np = (maxv - o < 0) ? 0 : maxv - o;
`else
                np = maxv;
`endif
            end else begin
                np = pos + step;
            end
        end else begin
            if (step >= pos) begin
                h = 1;
`ifdef SPRITE_MOTION_BOUNCE_EN
                o  = step - pos;
                np = (o > maxv) ? maxv : o;
`else
                np = 0;
`endif
            end else begin
                np = pos - step;
            end
        end
    endfunction

    task automatic model_frame(input logic [31:0] xs, input logic [31:0] xd,
                               input logic [31:0] ys, input logic [31:0] yd);
        int np;
        bit h;
        model_axis(mX, xs, xd[0], mFX, XM, np, h);
        mX = np; mHX = h;
`ifdef SPRITE_MOTION_BOUNCE_EN
        if (h) mFX = ~mFX;
`endif
        model_axis(mY, ys, yd[0], mFY, YM, np, h);
        mY = np; mHY = h;
`ifdef SPRITE_MOTION_BOUNCE_EN
        if (h) mFY = ~mFY;
`endif
    endtask

    task automatic model_load(input int lx, input int ly);
        mX = (lx > XM) ? XM : lx;
        mY = (ly > YM) ? YM : ly;
        mFX = 0; mFY = 0;
    endtask

    task automatic model_reset();
        mX = 312; mY = 232; mFX = 0; mFY = 0;
    endtask

    // Called just after an edge with the DUT idle; leaves the DUT idle again.
    task automatic do_frame(input logic [31:0] xs, input logic [31:0] xd,
                            input logic [31:0] ys, input logic [31:0] yd);
        xSpeed = xs; xDirection = xd; ySpeed = ys; yDirection = yd;
        motion_en = 1'b1;
        frame_tick = 1'b1;
        @(posedge clock); #1;
        frame_tick = 1'b0;
        obsBusy0 = busy;
        @(posedge clock); #1;
        obsX1 = pos_x; obsY1 = pos_y; obsV1 = pos_valid;
        @(posedge clock); #1;
        obsX2 = pos_x; obsY2 = pos_y; obsV2 = pos_valid; obsHX = hit_x; obsHY = hit_y;
        @(posedge clock); #1;
        obsV3 = pos_valid; obsBusy3 = busy;
    endtask

    task automatic do_load(input logic [9:0] lx, input logic [9:0] ly);
        load_x = lx; load_y = ly; load_pos = 1'b1;
        @(posedge clock); #1;
        load_pos = 1'b0;
    endtask

    task automatic test_reset();
        ctrl_reset_n = 1'b0;
        frame_tick = 0; motion_en = 0; load_pos = 0; clear_status = 0;
        xSpeed = 0; xDirection = 0; ySpeed = 0; yDirection = 0; load_x = 0; load_y = 0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        ctrl_reset_n = 1'b1;
        @(posedge clock); #1;
        vectors++; if (pos_x !== 10'd312) begin miscompares++; $display("FAIL reset_pos_x got=%0d exp=312", pos_x); end
        vectors++; if (pos_y !== 10'd232) begin miscompares++; $display("FAIL reset_pos_y got=%0d exp=232", pos_y); end
        vectors++; if ({pos_valid, hit_x, hit_y, busy, overrun} !== 5'b0) begin
            miscompares++; $display("FAIL reset_flags got=%b exp=00000", {pos_valid, hit_x, hit_y, busy, overrun}); end
    endtask

    task automatic test_basic();
        model_frame(32'd5, 32'd1, 32'd0, 32'd0);
        do_frame(32'd5, 32'd1, 32'd0, 32'd0);
        vectors++; if (obsBusy0 !== 1'b1) begin miscompares++; $display("FAIL basic_busy got=%b exp=1", obsBusy0); end
        vectors++; if (obsX1 !== 10'd317) begin miscompares++; $display("FAIL basic_pos_x_edge1 got=%0d exp=317", obsX1); end
        vectors++; if (obsV1 !== 1'b0) begin miscompares++; $display("FAIL basic_valid_early got=%b exp=0", obsV1); end
        vectors++; if (obsY2 !== 10'd232) begin miscompares++; $display("FAIL basic_pos_y got=%0d exp=232", obsY2); end
        vectors++; if (obsV2 !== 1'b1) begin miscompares++; $display("FAIL basic_valid got=%b exp=1", obsV2); end
        vectors++; if ({obsHX, obsHY} !== 2'b00) begin miscompares++; $display("FAIL basic_hits got=%b exp=00", {obsHX, obsHY}); end
        vectors++; if ({obsV3, obsBusy3} !== 2'b00) begin miscompares++; $display("FAIL basic_end got=%b exp=00", {obsV3, obsBusy3}); end
    endtask

    task automatic test_clamp_hit();
        logic [9:0] exp1, exp2;
        do_load(10'd620, 10'd232);
        model_load(620, 232);
        vectors++; if (pos_x !== 10'd620) begin miscompares++; $display("FAIL load_x got=%0d exp=620", pos_x); end
`ifdef SPRITE_MOTION_BOUNCE_EN
        exp1 = 10'd618; exp2 = 10'd608;
`else
        exp1 = 10'd624; exp2 = 10'd624;
`endif
        model_frame(32'd10, 32'd1, 32'd0, 32'd1);
        do_frame(32'd10, 32'd1, 32'd0, 32'd1);
        vectors++; if (obsX1 !== exp1) begin miscompares++; $display("FAIL clamp_x got=%0d exp=%0d", obsX1, exp1); end
        vectors++; if (obsHX !== 1'b1) begin miscompares++; $display("FAIL clamp_hit_x got=%b exp=1", obsHX); end
        model_frame(32'd10, 32'd1, 32'd0, 32'd1);
        do_frame(32'd10, 32'd1, 32'd0, 32'd1);
        vectors++; if (obsX1 !== exp2) begin miscompares++; $display("FAIL clamp_x_second got=%0d exp=%0d", obsX1, exp2); end
    endtask

    task automatic test_saturate();
        logic [9:0] expY;
        do_load(10'd624, 10'd3);
        model_load(624, 3);
`ifdef SPRITE_MOTION_BOUNCE_EN
        expY = 10'd12;
`else
        expY = 10'd0;
`endif
        model_frame(32'd0, 32'd1, 32'hFFFF_FFFF, 32'd0);
        do_frame(32'd0, 32'd1, 32'hFFFF_FFFF, 32'd0);
        vectors++; if (obsY2 !== expY) begin miscompares++; $display("FAIL sat_pos_y got=%0d exp=%0d", obsY2, expY); end
        vectors++; if (obsHY !== 1'b1) begin miscompares++; $display("FAIL sat_hit_y got=%b exp=1", obsHY); end
        // Zero step parked on the upper bound: no movement, no hit.
        vectors++; if (obsX2 !== 10'd624) begin miscompares++; $display("FAIL zero_step_x got=%0d exp=624", obsX2); end
        vectors++; if (obsHX !== 1'b0) begin miscompares++; $display("FAIL zero_step_hit got=%b exp=0", obsHX); end
        // Speed with only high bits set must still saturate, not truncate to zero.
        model_frame(32'h0001_0000, 32'd0, 32'd0, 32'd1);
        do_frame(32'h0001_0000, 32'd0, 32'd0, 32'd1);
        vectors++; if (obsX1 !== mX[9:0]) begin miscompares++; $display("FAIL highbit_speed got=%0d exp=%0d", obsX1, mX); end
        // Load beyond the bound clamps.
        do_load(10'd1000, 10'd1000);
        model_load(1000, 1000);
        vectors++; if ({pos_x, pos_y} !== {10'd624, 10'd464}) begin
            miscompares++; $display("FAIL load_clamp got=(%0d,%0d) exp=(624,464)", pos_x, pos_y); end
    endtask

    task automatic test_overrun();
        int nValid;
        xSpeed = 32'd3; xDirection = 32'd0; ySpeed = 32'd2; yDirection = 32'd0;
        model_frame(32'd3, 32'd0, 32'd2, 32'd0);
        motion_en = 1'b1;
        frame_tick = 1'b1;
        @(posedge clock); #1;            // edge 0 starts the update, tick stays high into STEP_X
        @(posedge clock); #1;
        frame_tick = 1'b0;
        nValid = pos_valid ? 1 : 0;
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_set got=%b exp=1", overrun); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (pos_valid) nValid++;
        end
        vectors++; if (nValid !== 1) begin miscompares++; $display("FAIL overrun_valid_count got=%0d exp=1", nValid); end
        vectors++; if ({pos_x, pos_y} !== {mX[9:0], mY[9:0]}) begin
            miscompares++; $display("FAIL overrun_pos got=(%0d,%0d) exp=(%0d,%0d)", pos_x, pos_y, mX, mY); end
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
        clear_status = 1'b1;
        @(posedge clock); #1;
        clear_status = 1'b0;
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL overrun_clear got=%b exp=0", overrun); end
        // Set and clear in the same cycle: set wins.
        model_frame(32'd3, 32'd0, 32'd2, 32'd0);
        frame_tick = 1'b1;
        @(posedge clock); #1;
        clear_status = 1'b1;
        @(posedge clock); #1;
        frame_tick = 1'b0; clear_status = 1'b0;
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_set_wins got=%b exp=1", overrun); end
        repeat (3) @(posedge clock);
        #1;
        clear_status = 1'b1;
        @(posedge clock); #1;
        clear_status = 1'b0;
    endtask

    task automatic test_reset_mid();
        int nValid = 0;
        xSpeed = 32'd7; xDirection = 32'd1; ySpeed = 32'd7; yDirection = 32'd1;
        frame_tick = 1'b1;
        @(posedge clock); #1;
        frame_tick = 1'b0;
        @(posedge clock); #1;            // now in STEP_Y
        ctrl_reset_n = 1'b0;
        model_reset();
        #1;
        vectors++; if ({pos_x, pos_y} !== {10'd312, 10'd232}) begin
            miscompares++; $display("FAIL midreset_pos got=(%0d,%0d) exp=(312,232)", pos_x, pos_y); end
        vectors++; if ({busy, pos_valid} !== 2'b00) begin
            miscompares++; $display("FAIL midreset_flags got=%b exp=00", {busy, pos_valid}); end
        @(posedge clock); #1;
        ctrl_reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            if (pos_valid) nValid++;
        end
        vectors++; if (nValid !== 0) begin miscompares++; $display("FAIL midreset_no_valid got=%0d exp=0", nValid); end
    endtask

    task automatic test_load_abort();
        int nValid = 0;
        xSpeed = 32'd4; xDirection = 32'd1; ySpeed = 32'd4; yDirection = 32'd1;
        frame_tick = 1'b1;
        @(posedge clock); #1;            // now in STEP_X
        frame_tick = 1'b0;
        load_x = 10'd100; load_y = 10'd50; load_pos = 1'b1;
        model_load(100, 50);
        @(posedge clock); #1;
        load_pos = 1'b0;
        vectors++; if ({pos_x, pos_y} !== {10'd100, 10'd50}) begin
            miscompares++; $display("FAIL loadabort_pos got=(%0d,%0d) exp=(100,50)", pos_x, pos_y); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL loadabort_busy got=%b exp=0", busy); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            if (pos_valid) nValid++;
        end
        vectors++; if (nValid !== 0) begin miscompares++; $display("FAIL loadabort_no_valid got=%0d exp=0", nValid); end
        vectors++; if ({pos_x, pos_y} !== {10'd100, 10'd50}) begin
            miscompares++; $display("FAIL loadabort_hold got=(%0d,%0d) exp=(100,50)", pos_x, pos_y); end
    endtask

    task automatic test_motion_en();
        int nBusy = 0;
        xSpeed = 32'd9; xDirection = 32'd1; ySpeed = 32'd9; yDirection = 32'd1;
        motion_en = 1'b0;
        frame_tick = 1'b1;
        @(posedge clock); #1;
        frame_tick = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (busy || pos_valid) nBusy++;
            @(posedge clock); #1;
        end
        vectors++; if (nBusy !== 0) begin miscompares++; $display("FAIL motion_off_busy got=%0d exp=0", nBusy); end
        vectors++; if ({pos_x, pos_y} !== {mX[9:0], mY[9:0]}) begin
            miscompares++; $display("FAIL motion_off_pos got=(%0d,%0d) exp=(%0d,%0d)", pos_x, pos_y, mX, mY); end
        motion_en = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] xs, xd, ys, yd;
        int prevY;
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 5) == 0) begin
                xs = 32'($urandom_range(0, 1023));
                ys = 32'($urandom_range(0, 1023));
                do_load(xs[9:0], ys[9:0]);
                model_load(int'(xs), int'(ys));
                vectors++; if ({pos_x, pos_y} !== {mX[9:0], mY[9:0]}) begin
                    miscompares++; $display("FAIL rand_load got=(%0d,%0d) exp=(%0d,%0d)", pos_x, pos_y, mX, mY); end
            end
            xs = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
            ys = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
            xd = $urandom;
            yd = $urandom;
            prevY = mY;
            model_frame(xs, xd, ys, yd);
            do_frame(xs, xd, ys, yd);
            vectors++; if ({obsX1, obsY1} !== {mX[9:0], prevY[9:0]}) begin
                miscompares++; $display("FAIL rand_edge1 f=%0d got=(%0d,%0d) exp=(%0d,%0d)", f, obsX1, obsY1, mX, prevY); end
            vectors++; if (obsY2 !== mY[9:0]) begin
                miscompares++; $display("FAIL rand_pos_y f=%0d got=%0d exp=%0d", f, obsY2, mY); end
            vectors++; if ({obsV1, obsV2, obsV3, obsHX, obsHY} !== {1'b0, 1'b1, 1'b0, mHX, mHY}) begin
                miscompares++; $display("FAIL rand_flags f=%0d got=%b exp=%b", f,
                    {obsV1, obsV2, obsV3, obsHX, obsHY}, {1'b0, 1'b1, 1'b0, mHX, mHY}); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp_hit();
        test_saturate();
        test_overrun();
        test_reset_mid();
        test_load_abort();
        test_motion_en();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
